video_retimer_scaled: RTL
=========================

Name: video_retimer_scaled

Overview:
Single-clock frame-buffer retimer that captures the console's native pixel stream and replays it on a fixed progressive output raster.
Generalises the earlier retimer:
- parametrised source size, colour depth, integer scale (1 or 2) and full output timing;
- centred window with programmable border colour;
- correct vertical total, proper bit-replication colour expansion, overflow detection;
- clean input resynchronisation after reset.
Sits between the core's video output and the HDMI/VGA encoder; both sides run on clk_sys, and the pixel rates are set by enables.

Parameters:
CBITS, 4, stored bits per colour channel (1..8); framebuffer word = 3*CBITS
IN_W, 256, source pixels per line
IN_H, 224, source lines per frame
SCALE, 2, integer upscale factor, 1 or 2
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, output horizontal timing in output pixels
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, output vertical timing in lines
HS_POL, 0, hsync_out active level (0 = active-low)
VS_POL, 0, vsync_out active level

Ports:
clk_sys  in  1  single system clock
reset  in  1  synchronous, active-high
dot_clock  in  1  source dot clock as a level signal; rising edge = one source pixel slot
R_in, G_in, B_in  in  8 each  source colour; upper CBITS bits are stored
input_valid  in  1  source pixel is active
hsync_in  in  1  source horizontal sync, active-high
vblank_in  in  1  source vertical blank, active-high
ce_out  in  1  output pixel enable; one output pixel per asserted cycle
border_rgb  in  24  {R,G,B} colour for active area outside the image window
R_out, G_out, B_out  out  8 each  output colour
output_blank  out  1  1 outside the active area
hsync_out, vsync_out  out  1  output syncs, polarity set by HS_POL/VS_POL
in_overflow  out  1  sticky: a write was attempted beyond IN_W or IN_H
frame_toggle  out  1  toggles on every vblank_in rising edge

Behaviour:
Reset values:
- Outputs: RGB = 0, output_blank = 1, hsync_out = !HS_POL, vsync_out = !VS_POL, in_overflow = 0, frame_toggle = 0.
- Counters: all output counters 0.
- Framebuffer contents are not cleared.

Input side, every clk_sys:
- dot strobe = registered (dot_clock && !dot_clock_last).
- Priority: vblank_in > hsync_in > pixel.
- vblank_in: hctr = 0, vctr = 0, input armed.
- hsync_in: hctr = 0. On the hsync_in rising edge, vctr += 1 only if hctr != 0 (the line carried pixels).
- Pixel = input_valid && strobe:
  - if hctr < IN_W and vctr < IN_H and armed: write mem[vctr*IN_W + hctr] = {R_in[7:8-CBITS], G_in.., B_in..};
  - otherwise set in_overflow;
  - hctr increments, saturating at IN_W.
- Reset disarms the input. No writes occur until the next vblank_in, so a partial frame is never written misaligned.
- Non-power-of-two IN_W must work (linear addressing). The output side must not use a multiplier (incremental row-base address).

Output side:
- Counters advance only on ce_out cycles. HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- hctr wraps at HTOTAL-1 and increments vctr; vctr wraps at VTOTAL-1.
- Window origin X0 = (H_ACTIVE - IN_W*SCALE)/2, Y0 = (V_ACTIVE - IN_H*SCALE)/2. A negative value is an elaboration error.
- Inside the window, source pixel = ((h-X0)/SCALE, (v-Y0)/SCALE).
- Active area outside the window outputs border_rgb. Outside the active area: blank = 1, RGB = 0.
- hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v.
- Pipeline: counter state to outputs = exactly 2 ce_out ticks, with identical latency for RGB, blank and syncs. Outputs hold when ce_out = 0.
- Colour expansion: repeat the CBITS field MSB-first until 8 bits are filled (4-bit A -> AA; 5-bit 10110 -> 10110101).
- Same-address read/write in one cycle returns old or new data. Single buffer; tearing is allowed.
- Reset mid-frame: output restarts at (0,0) on the first ce_out after release.

Test Plan:
1. Reset, then ce_out = 1 continuously with defaults (tick 0 = first cycle after release) -> hsync_out low during ticks 658..753. Period 800 ticks; vsync_out low for 2 lines, period 420000 ticks; output_blank 0 at tick 2.
2. Write one frame with pixel(3,5) = R 0x3F, G 0xA0, B 0x5A and all other pixels 0 -> at output (h=70..71, v=26..27) RGB = 33 AA 55; (72,26) = 00 00 00.
3. border_rgb = 0x102030 -> output (10,10) = 10 20 30; (700,10): blank = 1, RGB = 0; (63,16) border, (64,16) image.
4. Send 300 valid strobes on source line 0 -> x 0..255 stored, in_overflow = 1 and stays 1; source line 1 data unaffected.
5. Pulse reset while the input is on line 100, then send pixels before vblank_in -> memory unchanged. After vblank_in, line 0 writes resume; frame_toggle = 1 after that vblank rise.
6. ce_out on alternate cycles -> outputs change only on ce_out cycles; hsync period 1600 clk_sys.

Source files
------------

// File: rtl/video_retimer_scaled_if.sv
// Source pixel stream and retimed output raster of video_retimer_scaled, grouped as one port.
interface video_retimer_scaled_if;
   // Source pixels are taken on a dot_clock rise while input_valid is high, with no back-pressure.
   // The output raster advances one pixel per ce_out cycle and holds all outputs otherwise.
   logic        dot_clock;
   logic [7:0]  R_in;
   logic [7:0]  G_in;
   logic [7:0]  B_in;
   logic        input_valid;
   logic        hsync_in;
   logic        vblank_in;
   logic        ce_out;
   logic [23:0] border_rgb;
   logic [7:0]  R_out;
   logic [7:0]  G_out;
   logic [7:0]  B_out;
   logic        output_blank;
   logic        hsync_out;
   logic        vsync_out;
   logic        in_overflow;
   logic        frame_toggle;

   modport master (
      output dot_clock, R_in, G_in, B_in, input_valid, hsync_in, vblank_in, ce_out, border_rgb,
      input  R_out, G_out, B_out, output_blank, hsync_out, vsync_out, in_overflow, frame_toggle
   );

   modport slave (
      input  dot_clock, R_in, G_in, B_in, input_valid, hsync_in, vblank_in, ce_out, border_rgb,
      output R_out, G_out, B_out, output_blank, hsync_out, vsync_out, in_overflow, frame_toggle
   );
endinterface

// File: rtl/video_retimer_scaled.sv
// Captures the source pixel stream into a single frame buffer and replays it,
// integer-scaled and centred inside a border, on a fixed progressive output raster.
module video_retimer_scaled #(
   parameter int CBITS    = 4,
   parameter int IN_W     = 256,
   parameter int IN_H     = 224,
   parameter int SCALE    = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   video_retimer_scaled_if.slave vid
);
   localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int WIN_W  = IN_W * SCALE;
   localparam int WIN_H  = IN_H * SCALE;
   localparam int X0     = (H_ACTIVE - WIN_W) / 2;
   localparam int Y0     = (V_ACTIVE - WIN_H) / 2;
   localparam int DEPTH  = IN_W * IN_H;
   localparam int AW     = $clog2(DEPTH);
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);
   localparam int IHW    = $clog2(IN_W + 1);
   localparam int IVW    = $clog2(IN_H + 1);
   localparam int WW     = 3 * CBITS;

   if (H_ACTIVE < WIN_W || V_ACTIVE < WIN_H) begin : g_bad_window
      $error("scaled source image does not fit in the active area");
   end
   if (SCALE != 1 && SCALE != 2) begin : g_bad_scale
      $error("SCALE must be 1 or 2");
   end

   function automatic logic [7:0] expand(input logic [CBITS-1:0] c);
      logic [7:0] e;
      e = '0;
      for (int i = 0; i < 8; i++) e[7-i] = c[CBITS-1-(i % CBITS)];
      return e;
   endfunction

   logic [WW-1:0] mem [DEPTH];

   // ---------------- input side ----------------
   logic           dot_last, strobe, hs_last, vb_last, armed, overflow_q, toggle_q;
   logic [IHW-1:0] in_h;
   logic [IVW-1:0] in_v;
   logic [AW-1:0]  in_base;
   logic           pix, in_range, wr_en;
   logic [AW-1:0]  wr_addr;
   logic [WW-1:0]  wr_data;
   logic           unused_src_lsbs;

   assign pix      = vid.input_valid && strobe;
   assign in_range = (in_h < IHW'(IN_W)) && (in_v < IVW'(IN_H));
   assign wr_en    = !reset && !vid.vblank_in && !vid.hsync_in && pix && in_range && armed;
   assign wr_addr  = in_base + AW'(in_h);
   assign wr_data  = {vid.R_in[7 -: CBITS], vid.G_in[7 -: CBITS], vid.B_in[7 -: CBITS]};
   assign unused_src_lsbs = ^{vid.R_in, vid.G_in, vid.B_in};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dot_last   <= 1'b0;
         strobe     <= 1'b0;
         hs_last    <= 1'b0;
         vb_last    <= 1'b0;
         armed      <= 1'b0;
         overflow_q <= 1'b0;
         toggle_q   <= 1'b0;
         in_h       <= '0;
         in_v       <= '0;
         in_base    <= '0;
      end else begin
         dot_last <= vid.dot_clock;
         strobe   <= vid.dot_clock && !dot_last;
         hs_last  <= vid.hsync_in;
         vb_last  <= vid.vblank_in;
         if (vid.vblank_in && !vb_last) toggle_q <= !toggle_q;
         if (vid.vblank_in) begin
            in_h    <= '0;
            in_v    <= '0;
            in_base <= '0;
            armed   <= 1'b1;
         end else if (vid.hsync_in) begin
            in_h <= '0;
            // Only a line that carried pixels advances the row; the row count saturates past the image.
            if (!hs_last && in_h != '0 && in_v < IVW'(IN_H)) begin
               in_v    <= in_v + IVW'(1);
               in_base <= in_base + AW'(IN_W);
            end
         end else if (pix) begin
            if (armed && !in_range) overflow_q <= 1'b1;
            if (in_h < IHW'(IN_W)) in_h <= in_h + IHW'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // ---------------- output side ----------------
   logic [HW-1:0] h_ctr, hx, col;
   logic [VW-1:0] v_ctr, vy;
   logic [AW-1:0] row_base, rd_addr;
   logic          in_x, in_y, active, hs_act, vs_act, row_done;

   // Offsets wrap below the window origin, so one unsigned compare covers both window edges.
   assign hx       = h_ctr - HW'(X0);
   assign vy       = v_ctr - VW'(Y0);
   assign in_x     = hx < HW'(WIN_W);
   assign in_y     = vy < VW'(WIN_H);
   assign col      = (SCALE == 2) ? (hx >> 1) : hx;
   assign rd_addr  = (in_x && in_y) ? row_base + AW'(col) : '0;
   assign active   = (h_ctr < HW'(H_ACTIVE)) && (v_ctr < VW'(V_ACTIVE));
   assign hs_act   = (h_ctr - HW'(H_ACTIVE + H_FP)) < HW'(H_SYNC);
   assign vs_act   = (v_ctr - VW'(V_ACTIVE + V_FP)) < VW'(V_SYNC);
   assign row_done = in_y && ((SCALE == 1) || vy[0]);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         h_ctr    <= '0;
         v_ctr    <= '0;
         row_base <= '0;
      end else if (vid.ce_out) begin
         if (h_ctr == HW'(HTOTAL - 1)) begin
            h_ctr <= '0;
            if (v_ctr == VW'(VTOTAL - 1)) begin
               v_ctr    <= '0;
               row_base <= '0;
            end else begin
               v_ctr <= v_ctr + VW'(1);
               if (row_done) row_base <= row_base + AW'(IN_W);
            end
         end else begin
            h_ctr <= h_ctr + HW'(1);
         end
      end
   end

   logic [WW-1:0] rd_data;
   logic          s1_active, s1_win, s1_hs, s1_vs;
   logic [7:0]    r_q, g_q, b_q;
   logic          blank_q, hs_q, vs_q;

   always_ff @(posedge clk_sys) begin
      if (vid.ce_out) rd_data <= mem[rd_addr];
   end

   // Stage 1 registers window/sync flags alongside the buffer read; stage 2 forms the pixel.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         s1_active <= 1'b0;
         s1_win    <= 1'b0;
         s1_hs     <= 1'b0;
         s1_vs     <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         blank_q   <= 1'b1;
         hs_q      <= !HS_POL;
         vs_q      <= !VS_POL;
      end else if (vid.ce_out) begin
         s1_active <= active;
         s1_win    <= active && in_x && in_y;
         s1_hs     <= hs_act;
         s1_vs     <= vs_act;
         blank_q   <= !s1_active;
         hs_q      <= s1_hs ? HS_POL : !HS_POL;
         vs_q      <= s1_vs ? VS_POL : !VS_POL;
         if (!s1_active) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
         end else if (s1_win) begin
            r_q <= expand(rd_data[3*CBITS-1 -: CBITS]);
            g_q <= expand(rd_data[2*CBITS-1 -: CBITS]);
            b_q <= expand(rd_data[CBITS-1:0]);
         end else begin
            {r_q, g_q, b_q} <= vid.border_rgb;
         end
      end
   end

   assign vid.R_out        = r_q;
   assign vid.G_out        = g_q;
   assign vid.B_out        = b_q;
   assign vid.output_blank = blank_q;
   assign vid.hsync_out    = hs_q;
   assign vid.vsync_out    = vs_q;
   assign vid.in_overflow  = overflow_q;
   assign vid.frame_toggle = toggle_q;
endmodule
